// File: rtl/sl_pkg.sv
// sl_pkg: shared definitions for the serial-line transmitter.
//   - FSM state encoding
//   - line encodings, packed as {SL1, SL0}
//   - default timing constants (16 MHz clock)
//   - small helpers for sizing and bit encoding
package sl_pkg;

    localparam int DEF_MAX_BITS  = 32;
    localparam int DEF_PULSE_CYC = 16;
    localparam int DEF_GAP_CYC   = 16;
    localparam int DEF_STOP_CYC  = 32;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_PULSE = 3'd1;
    localparam logic [2:0] ST_GAP   = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_TAIL  = 3'd4;

    // {SL1, SL0}: a line is pulled low to signal its bit value.
    localparam logic [1:0] LINE_IDLE = 2'b11;
    localparam logic [1:0] LINE_ONE  = 2'b01;
    localparam logic [1:0] LINE_ZERO = 2'b10;
    localparam logic [1:0] LINE_STOP = 2'b00;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic logic [1:0] line_bit(input logic b);
        return b ? LINE_ONE : LINE_ZERO;
    endfunction

endpackage

// File: rtl/sl_tx_param_if.sv
// sl_tx_param_if: word-offer handshake into the transmitter.
//   in_data    word to send, LSB first
//   in_len     data-bit count (0 or >MAX_BITS means MAX_BITS)
//   in_par_en  append a parity bit
//   in_par_odd 1 = odd parity, 0 = even
//   in_valid   word offered
//   in_ready   transmitter idle and able to take a word
interface sl_tx_param_if
    import sl_pkg::*;
#(
    parameter int MAX_BITS = DEF_MAX_BITS
);
    localparam int LW = $clog2(MAX_BITS + 1);

    logic [MAX_BITS-1:0] in_data;
    logic [LW-1:0]       in_len;
    logic                in_par_en;
    logic                in_par_odd;
    logic                in_valid;
    logic                in_ready;

    modport master (
        output in_data, in_len, in_par_en, in_par_odd, in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data, in_len, in_par_en, in_par_odd, in_valid,
        output in_ready
    );
endinterface

// File: rtl/sl_tx_timer.sv
// sl_tx_timer: loadable down-counter used to time every line phase.
//   clk, rst_n  clock, async active-low reset
//   load        load load_val this cycle (wins over counting)
//   load_val    cycles-1 of the phase being entered
//   expired     counter is at zero (last cycle of the current phase)
module sl_tx_timer #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            cnt <= '0;
        else if (load)         cnt <= load_val;
        else if (cnt != '0)    cnt <= cnt - W'(1);
    end

    assign expired = (cnt == '0);
endmodule

// File: rtl/sl_tx_param.sv
// sl_tx_param: two-wire serial-line word transmitter.
// Each bit is a low pulse on SL0 (bit 0) or SL1 (bit 1) followed by an idle
// gap; the word ends with both lines low (stop) and an idle tail.
//   clk, rst_n  clock, async active-low reset
//   bus         word handshake (slave side)
//   SL0, SL1    registered line outputs
//   busy        word in transmission (registered)
//   done        one-cycle pulse as the block returns to idle (registered)
module sl_tx_param
    import sl_pkg::*;
#(
    parameter int MAX_BITS  = DEF_MAX_BITS,
    parameter int PULSE_CYC = DEF_PULSE_CYC,
    parameter int GAP_CYC   = DEF_GAP_CYC,
    parameter int STOP_CYC  = DEF_STOP_CYC
) (
    input  logic          clk,
    input  logic          rst_n,
    sl_tx_param_if.slave  bus,
    output logic          SL0,
    output logic          SL1,
    output logic          busy,
    output logic          done
);
    localparam int LW = $clog2(MAX_BITS + 1);
    localparam int CW = $clog2(MAX_BITS + 2);
    localparam int TW = $clog2(max3(PULSE_CYC, GAP_CYC, STOP_CYC) + 1);

    localparam logic [TW-1:0] T_PULSE = TW'(PULSE_CYC - 1);
    localparam logic [TW-1:0] T_GAP   = TW'(GAP_CYC - 1);
    localparam logic [TW-1:0] T_STOP  = TW'(STOP_CYC - 1);

    logic [2:0]          state;
    logic [1:0]          line_q;
    logic [MAX_BITS-1:0] data_q;
    logic [LW-1:0]       len_q;
    logic [CW-1:0]       nbits_q;
    logic [CW-1:0]       idx_q;
    logic                par_acc;

    logic                accept;
    logic [LW-1:0]       len_eff;
    logic [CW-1:0]       idx_nxt;
    logic                more_bits;
    logic                nxt_is_data;
    logic [MAX_BITS-1:0] data_sh;
    logic                nxt_data_bit;
    logic                tmr_load;
    logic [TW-1:0]       tmr_val;
    logic                tmr_exp;

    // Gated by rst_n so the handshake is closed while reset is held.
    assign bus.in_ready = rst_n && (state == ST_IDLE);
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        len_eff = bus.in_len;
        if (bus.in_len == '0 || bus.in_len > LW'(MAX_BITS))
            len_eff = LW'(MAX_BITS);
    end

    assign idx_nxt      = idx_q + CW'(1);
    assign more_bits    = idx_nxt < nbits_q;
    assign nxt_is_data  = idx_nxt < CW'(len_q);
    assign data_sh      = data_q >> idx_nxt;
    assign nxt_data_bit = data_sh[0];

    // Timer reload on every phase entry; value is the new phase length - 1.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state)
            ST_IDLE:  if (accept)  begin tmr_load = 1'b1; tmr_val = T_PULSE; end
            ST_PULSE: if (tmr_exp) begin tmr_load = 1'b1; tmr_val = T_GAP;   end
            ST_GAP:   if (tmr_exp) begin
                          tmr_load = 1'b1;
                          tmr_val  = more_bits ? T_PULSE : T_STOP;
                      end
            ST_STOP:  if (tmr_exp) begin tmr_load = 1'b1; tmr_val = T_GAP;   end
            default: ;
        endcase
    end

    sl_tx_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_exp)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            line_q  <= LINE_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            data_q  <= '0;
            len_q   <= '0;
            nbits_q <= '0;
            idx_q   <= '0;
            par_acc <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: if (accept) begin
                    data_q  <= bus.in_data;
                    len_q   <= len_eff;
                    nbits_q <= CW'(len_eff) + CW'(bus.in_par_en);
                    idx_q   <= '0;
                    // Odd parity is folded in up front; bit 0 is always data.
                    par_acc <= bus.in_par_odd ^ bus.in_data[0];
                    line_q  <= line_bit(bus.in_data[0]);
                    busy    <= 1'b1;
                    state   <= ST_PULSE;
                end
                ST_PULSE: if (tmr_exp) begin
                    line_q <= LINE_IDLE;
                    state  <= ST_GAP;
                end
                ST_GAP: if (tmr_exp) begin
                    if (more_bits) begin
                        idx_q <= idx_nxt;
                        state <= ST_PULSE;
                        if (nxt_is_data) begin
                            line_q  <= line_bit(nxt_data_bit);
                            par_acc <= par_acc ^ nxt_data_bit;
                        end else begin
                            line_q  <= line_bit(par_acc);
                        end
                    end else begin
                        line_q <= LINE_STOP;
                        state  <= ST_STOP;
                    end
                end
                ST_STOP: if (tmr_exp) begin
                    line_q <= LINE_IDLE;
                    state  <= ST_TAIL;
                end
                ST_TAIL: if (tmr_exp) begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: begin
                    line_q <= LINE_IDLE;
                    busy   <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign SL0 = line_q[0];
    assign SL1 = line_q[1];
endmodule

// File: tb/tb_sl_tx_param.sv
module tb_sl_tx_param;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cur = 1'b0;   // 0 = default instance, 1 = fast 64-bit instance

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic a_sl0, a_sl1, a_busy, a_done;
    logic b_sl0, b_sl1, b_busy, b_done;
    logic m_sl0, m_sl1, m_busy, m_done, m_ready;

    sl_tx_param_if #(.MAX_BITS(32)) a_bus ();
    sl_tx_param_if #(.MAX_BITS(64)) b_bus ();

    sl_tx_param #(.MAX_BITS(32), .PULSE_CYC(16), .GAP_CYC(16), .STOP_CYC(32)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(a_bus.slave),
        .SL0(a_sl0), .SL1(a_sl1), .busy(a_busy), .done(a_done)
    );

    sl_tx_param #(.MAX_BITS(64), .PULSE_CYC(1), .GAP_CYC(1), .STOP_CYC(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(b_bus.slave),
        .SL0(b_sl0), .SL1(b_sl1), .busy(b_busy), .done(b_done)
    );

    assign m_sl0   = cur ? b_sl0 : a_sl0;
    assign m_sl1   = cur ? b_sl1 : a_sl1;
    assign m_busy  = cur ? b_busy : a_busy;
    assign m_done  = cur ? b_done : a_done;
    assign m_ready = cur ? b_bus.in_ready : a_bus.in_ready;

    task automatic drive(input logic sel, input logic [63:0] d, input logic [6:0] l,
                         input logic pe, input logic po, input logic v);
        if (!sel) begin
            a_bus.in_data = d[31:0]; a_bus.in_len = l[5:0];
            a_bus.in_par_en = pe; a_bus.in_par_odd = po; a_bus.in_valid = v;
        end else begin
            b_bus.in_data = d; b_bus.in_len = l;
            b_bus.in_par_en = pe; b_bus.in_par_odd = po; b_bus.in_valid = v;
        end
    endtask

    // Offer one word, scramble the inputs right after acceptance, then record
    // the decoded pulse sequence until done.
    task automatic send_word(input logic sel, input logic [63:0] d, input logic [6:0] l,
                             input logic pe, input logic po,
                             output int nb, output logic [64:0] bits, output int busy_c,
                             output int stop_c, output int done_c, output int tmo);
        logic [1:0] line, prev;
        cur = sel;
        nb = 0; bits = '0; busy_c = 0; stop_c = 0; done_c = 0; tmo = 1;
        @(negedge clk);
        drive(sel, d, l, pe, po, 1'b1);
        @(posedge clk); #1;
        drive(sel, ~d, 7'd1, ~pe, ~po, 1'b0);
        prev = 2'b11;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            line = {m_sl1, m_sl0};
            if (m_busy) busy_c++;
            if (line == 2'b00) stop_c++;
            if (prev == 2'b11 && (line == 2'b01 || line == 2'b10)) begin
                if (line == 2'b01) bits = bits | (65'd1 << nb);
                nb++;
            end
            prev = line;
            if (m_done) begin done_c++; tmo = 0; break; end
        end
    endtask

    task automatic test_reset;
        a_bus.in_valid = 1'b0; b_bus.in_valid = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++; if ({a_sl1, a_sl0} !== 2'b11) begin n_fail++; $display("FAIL reset_lines: got %b expected 11", {a_sl1, a_sl0}); end
        n_tests++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", a_busy); end
        n_tests++; if (a_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", a_done); end
        n_tests++; if (a_bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", a_bus.in_ready); end
        n_tests++; if (b_bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_b: got %b expected 0", b_bus.in_ready); end
        rst_n = 1'b1;
        #1;
        n_tests++; if (a_bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL release_ready: got %b expected 1", a_bus.in_ready); end
        @(negedge clk);
        n_tests++; if ({a_sl1, a_sl0, a_busy} !== 3'b110) begin n_fail++; $display("FAIL idle_after_release: got %b expected 110", {a_sl1, a_sl0, a_busy}); end
    endtask

    task automatic test_basic;
        int nb, bc, sc, dc, tmo;
        logic [64:0] bits;
        send_word(1'b0, 64'hA5, 7'd8, 1'b0, 1'b0, nb, bits, bc, sc, dc, tmo);
        n_tests++; if (tmo !== 0) begin n_fail++; $display("FAIL basic_timeout: got %0d expected 0", tmo); end
        n_tests++; if (nb !== 8) begin n_fail++; $display("FAIL basic_nbits: got %0d expected 8", nb); end
        n_tests++; if (bits !== 65'hA5) begin n_fail++; $display("FAIL basic_bits: got %h expected a5", bits); end
        n_tests++; if (bc !== 304) begin n_fail++; $display("FAIL basic_busy: got %0d expected 304", bc); end
        n_tests++; if (sc !== 32) begin n_fail++; $display("FAIL basic_stop: got %0d expected 32", sc); end
        n_tests++; if (dc !== 1) begin n_fail++; $display("FAIL basic_done: got %0d expected 1", dc); end
        n_tests++; if (m_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready_at_done: got %b expected 1", m_ready); end
        @(negedge clk);
        n_tests++; if (m_done !== 1'b0) begin n_fail++; $display("FAIL basic_done_width: got %b expected 0", m_done); end
    endtask

    task automatic test_parity;
        int nb, bc, sc, dc, tmo;
        logic [64:0] bits;
        send_word(1'b0, 64'h7, 7'd3, 1'b1, 1'b0, nb, bits, bc, sc, dc, tmo);
        n_tests++; if (nb !== 4) begin n_fail++; $display("FAIL par_even_nbits: got %0d expected 4", nb); end
        n_tests++; if (bits !== 65'hF) begin n_fail++; $display("FAIL par_even_bits: got %h expected f", bits); end
        n_tests++; if (bc !== 176) begin n_fail++; $display("FAIL par_even_busy: got %0d expected 176", bc); end
        send_word(1'b0, 64'h7, 7'd3, 1'b1, 1'b1, nb, bits, bc, sc, dc, tmo);
        n_tests++; if (nb !== 4) begin n_fail++; $display("FAIL par_odd_nbits: got %0d expected 4", nb); end
        n_tests++; if (bits !== 65'h7) begin n_fail++; $display("FAIL par_odd_bits: got %h expected 7", bits); end
        n_tests++; if (tmo !== 0) begin n_fail++; $display("FAIL par_timeout: got %0d expected 0", tmo); end
    endtask

    task automatic test_clamp;
        int nb, bc, sc, dc, tmo;
        logic [64:0] bits;
        send_word(1'b0, 64'hC3A50F96, 7'd0, 1'b0, 1'b0, nb, bits, bc, sc, dc, tmo);
        n_tests++; if (nb !== 32) begin n_fail++; $display("FAIL len0_nbits: got %0d expected 32", nb); end
        n_tests++; if (bits !== 65'hC3A50F96) begin n_fail++; $display("FAIL len0_bits: got %h expected c3a50f96", bits); end
        n_tests++; if (bc !== 1072) begin n_fail++; $display("FAIL len0_busy: got %0d expected 1072", bc); end
        send_word(1'b0, 64'h80000001, 7'd40, 1'b0, 1'b0, nb, bits, bc, sc, dc, tmo);
        n_tests++; if (nb !== 32) begin n_fail++; $display("FAIL len40_nbits: got %0d expected 32", nb); end
        n_tests++; if (bits !== 65'h80000001) begin n_fail++; $display("FAIL len40_bits: got %h expected 80000001", bits); end
    endtask

    task automatic test_back_to_back;
        logic [1:0] line, prev;
        int c, done_cyc, first_pulse, viol, ndone, nb1, nb2, finished;
        logic [64:0] b1, b2;
        cur = 1'b0;
        done_cyc = -1; first_pulse = -1; viol = 0; ndone = 0; nb1 = 0; nb2 = 0; finished = 0;
        b1 = '0; b2 = '0; prev = 2'b11;
        @(negedge clk);
        drive(1'b0, 64'h9, 7'd4, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        drive(1'b0, 64'h6, 7'd4, 1'b0, 1'b0, 1'b1);
        for (c = 0; c < 2000; c++) begin
            @(negedge clk);
            line = {a_sl1, a_sl0};
            if (a_busy && a_bus.in_ready) viol++;
            if (prev == 2'b11 && (line == 2'b01 || line == 2'b10)) begin
                if (ndone == 0) begin
                    if (line == 2'b01) b1 = b1 | (65'd1 << nb1);
                    nb1++;
                end else begin
                    if (first_pulse < 0) begin first_pulse = c; a_bus.in_valid = 1'b0; end
                    if (line == 2'b01) b2 = b2 | (65'd1 << nb2);
                    nb2++;
                end
            end
            prev = line;
            if (a_done) begin
                ndone++;
                if (done_cyc < 0) done_cyc = c;
                if (ndone == 2) begin finished = 1; break; end
            end
        end
        a_bus.in_valid = 1'b0;
        n_tests++; if (finished !== 1) begin n_fail++; $display("FAIL b2b_timeout: got %0d expected 1", finished); end
        n_tests++; if (first_pulse !== done_cyc + 1) begin n_fail++; $display("FAIL b2b_latency: got %0d expected %0d", first_pulse, done_cyc + 1); end
        n_tests++; if (b1 !== 65'h9 || nb1 !== 4) begin n_fail++; $display("FAIL b2b_word1: got %h/%0d expected 9/4", b1, nb1); end
        n_tests++; if (b2 !== 65'h6 || nb2 !== 4) begin n_fail++; $display("FAIL b2b_word2: got %h/%0d expected 6/4", b2, nb2); end
        n_tests++; if (viol !== 0) begin n_fail++; $display("FAIL b2b_ready_busy: got %0d expected 0", viol); end
    endtask

    task automatic test_reset_mid;
        logic [1:0] line, prev;
        int pulses, bad;
        cur = 1'b0; pulses = 0; prev = 2'b11; bad = 0;
        @(negedge clk);
        drive(1'b0, 64'hA5, 7'd8, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        a_bus.in_valid = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            line = {a_sl1, a_sl0};
            if (prev == 2'b11 && line != 2'b11) pulses++;
            prev = line;
            if (pulses == 5) break;
        end
        @(negedge clk);
        n_tests++; if ({a_sl1, a_sl0} !== 2'b10) begin n_fail++; $display("FAIL mid_pulse5: got %b expected 10", {a_sl1, a_sl0}); end
        #2 rst_n = 1'b0;
        #1;
        n_tests++; if ({a_sl1, a_sl0, a_busy} !== 3'b110) begin n_fail++; $display("FAIL mid_async: got %b expected 110", {a_sl1, a_sl0, a_busy}); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_tests++; if (a_bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready: got %b expected 1", a_bus.in_ready); end
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if ({a_sl1, a_sl0} != 2'b11 || a_busy || a_done) bad++;
        end
        n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL mid_no_stop: got %0d expected 0", bad); end
    endtask

    task automatic test_fast64;
        int nb, bc, sc, dc, tmo;
        logic [64:0] bits;
        send_word(1'b1, 64'h0123456789ABCDEF, 7'd64, 1'b0, 1'b0, nb, bits, bc, sc, dc, tmo);
        n_tests++; if (tmo !== 0) begin n_fail++; $display("FAIL fast_timeout: got %0d expected 0", tmo); end
        n_tests++; if (bc !== 130) begin n_fail++; $display("FAIL fast_busy: got %0d expected 130", bc); end
        n_tests++; if (nb !== 64) begin n_fail++; $display("FAIL fast_nbits: got %0d expected 64", nb); end
        n_tests++; if (bits !== {1'b0, 64'h0123456789ABCDEF}) begin n_fail++; $display("FAIL fast_bits: got %h expected 0123456789abcdef", bits); end
        n_tests++; if (sc !== 1) begin n_fail++; $display("FAIL fast_stop: got %0d expected 1", sc); end
    endtask

    initial begin
        drive(1'b0, 64'h0, 7'd0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 64'h0, 7'd0, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_basic();
        test_parity();
        test_clamp();
        test_back_to_back();
        test_reset_mid();
        test_fast64();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
